// File: rtl/digit_scan_driver.sv
// Multiplexed 7-segment scan driver.
// Walks one digit slot at a time, blanks all anodes at the start of each slot
// to suppress ghosting, and swaps in newly loaded data only at frame edges so
// a single scan never shows a mix of old and new values.
module digit_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [0:0]              state;
    logic                    slot_wrap;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_en;

    logic [NUM_DIGITS:0]     zero_from;
    logic [NUM_DIGITS-1:0]   suppressed;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_sup;
    logic [NUM_DIGITS-1:0]   an_onehot;

    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign state     = (cnt < BLANK_END) ? ST_BLANK : ST_DRIVE;
    assign slot_wrap = (cnt == CNT_LAST);
    assign frame_end = slot_wrap && (idx == IDX_LAST);

    // A digit is a leading zero when it and every higher digit show 0 with no point lit.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (act_digits[4*i +: 4] == 4'h0) & ~act_dp[i];
        end
        suppressed    = lz_en ? zero_from[NUM_DIGITS-1:0] : '0;
        suppressed[0] = 1'b0;
    end

    // Pick out the data belonging to the digit currently being scanned.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_sup   = 1'b0;
        an_onehot = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib      = act_digits[4*i +: 4];
                cur_dp       = act_dp[i];
                cur_en       = act_en[i];
                cur_sup      = suppressed[i];
                an_onehot[i] = 1'b0;
            end
        end
    end

    // Dark unless the slot is past its blanking window and the digit is visible.
    always_comb begin
        an_next  = '1;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (state != ST_BLANK && cur_en && !cur_sup) begin
            an_next  = an_onehot;
            seg_next = decode(cur_nib);
            dp_next  = ~cur_dp;
        end
    end

    // Slot timer and digit index that together sweep one frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Double-buffered display data: loads land in pending, promoted at frame edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
        end else begin
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp_in;
                pend_en     <= digit_en;
            end
            if (frame_end) begin
                act_digits <= load ? digits   : pend_digits;
                act_dp     <= load ? dp_in    : pend_dp;
                act_en     <= load ? digit_en : pend_en;
            end
        end
    end

    // Registered pin drive and end-of-scan pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: a frame-position model predicts every output
// each cycle, and literal checks pin the model at hand-computed points.
module tb_digit_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n;
    logic [15:0] m_pend_d, m_act_d;
    logic [3:0]  m_pend_dp, m_act_dp, m_pend_en, m_act_en;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;
    int          m_slot, m_dig;
    bit          m_sup, m_bound;

    digit_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference: n is the position within the frame, derived purely from edges since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            m_pend_d = '0; m_pend_dp = '0; m_pend_en = '0;
            m_act_d  = '0; m_act_dp  = '0; m_act_en  = '0;
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            m_slot = n % RD;
            m_dig  = n / RD;
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
            if (m_slot >= BC) begin
                m_sup = lz_en && (m_dig > 0);
                for (int j = m_dig; j < ND; j++)
                    if (m_act_d[4*j +: 4] != 4'h0 || m_act_dp[j]) m_sup = 1'b0;
                if (m_act_en[m_dig] && !m_sup) begin
                    exp_an  = 4'(~(4'b0001 << m_dig));
                    exp_seg = seg_tab[m_act_d[4*m_dig +: 4]];
                    exp_dp  = ~m_act_dp[m_dig];
                end
            end
            m_bound = (n == FRAME - 1);
            if (load) begin
                m_pend_d = digits; m_pend_dp = dp_in; m_pend_en = digit_en;
            end
            if (m_bound) begin
                m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
            end
            exp_fd = m_bound;
            n = (n + 1) % FRAME;
        end
    end

    task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b (frame pos %0d, t=%0t)", name, got, want, n, $time);
        end
    endtask

    // Every cycle out of reset the pins must match the model.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            cmp("model_an",  {3'b000, an},         {3'b000, exp_an});
            cmp("model_seg", seg,                  exp_seg);
            cmp("model_dp",  {6'b000000, dp},      {6'b000000, exp_dp});
            cmp("model_fd",  {6'b000000, frame_done}, {6'b000000, exp_fd});
        end
    end

    task automatic check_output(input string name, input logic [3:0] ean,
                                input logic [6:0] eseg, input logic edp);
        cmp({name, "_an"},  {3'b000, an},    {3'b000, ean});
        cmp({name, "_seg"}, seg,             eseg);
        cmp({name, "_dp"},  {6'b000000, dp}, {6'b000000, edp});
    endtask

    task automatic check_fd(input string name, input logic efd);
        cmp(name, {6'b000000, frame_done}, {6'b000000, efd});
    endtask

    // Advance to the negedge where the model frame position equals target.
    task automatic wait_n(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            @(negedge clk);
            if (n == target) hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_pos: got timeout want pos %0d", target);
        end
    endtask

    // One-cycle load strobe starting at the current negedge.
    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
        digits   = d;
        digit_en = en;
        dp_in    = p;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; lz_en = 1'b0;
        digits = '0; digit_en = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        check_output("reset", 4'b1111, 7'b1111111, 1'b1);
        check_fd("reset_fd", 1'b0);
        rst = 1'b0;
        check_en = 1'b1;

        // Basic hex display of 12AF.
        apply_stimulus(16'h12AF, 4'hF, 4'h0);
        wait_n(0);  check_fd("fd_high", 1'b1);
        wait_n(1);  check_fd("fd_low", 1'b0);
        wait_n(2);  check_output("idx0_blank", 4'b1111, 7'b1111111, 1'b1);
        wait_n(3);  check_output("idx0_F", 4'b1110, 7'b0001110, 1'b1);
        wait_n(30); check_output("idx3_1", 4'b0111, 7'b1111001, 1'b1);

        // Leading-zero suppression.
        lz_en = 1'b1;
        apply_stimulus(16'h0050, 4'hF, 4'h0);
        wait_n(0);
        wait_n(4);  check_output("lz_idx0", 4'b1110, 7'b1000000, 1'b1);
        wait_n(12); check_output("lz_idx1", 4'b1101, 7'b0010010, 1'b1);
        wait_n(20); check_output("lz_idx2", 4'b1111, 7'b1111111, 1'b1);
        wait_n(28); check_output("lz_idx3", 4'b1111, 7'b1111111, 1'b1);
        apply_stimulus(16'h0000, 4'hF, 4'h0);
        wait_n(0);
        wait_n(4);  check_output("lz0_idx0", 4'b1110, 7'b1000000, 1'b1);
        wait_n(12); check_output("lz0_idx1", 4'b1111, 7'b1111111, 1'b1);

        // Two loads in one frame: only the last is shown.
        lz_en = 1'b0;
        wait_n(5);  apply_stimulus(16'h1111, 4'hF, 4'h0);
        wait_n(10); apply_stimulus(16'h2222, 4'hF, 4'h0);
        wait_n(0);
        wait_n(4);  check_output("dbl_idx0", 4'b1110, 7'b0100100, 1'b1);
        wait_n(28); check_output("dbl_idx3", 4'b0111, 7'b0100100, 1'b1);

        // Load landing exactly on the frame boundary.
        wait_n(31);
        apply_stimulus(16'h3333, 4'hF, 4'h0);
        check_fd("bnd_fd", 1'b1);
        wait_n(1);  check_fd("bnd_fd_low", 1'b0);
        wait_n(4);  check_output("bnd_idx0", 4'b1110, 7'b0110000, 1'b1);

        // Per-digit enable and decimal point.
        apply_stimulus(16'h8888, 4'b1010, 4'b0010);
        wait_n(0);
        wait_n(4);  check_output("en_idx0", 4'b1111, 7'b1111111, 1'b1);
        wait_n(12); check_output("en_idx1", 4'b1101, 7'b0000000, 1'b0);
        wait_n(20); check_output("en_idx2", 4'b1111, 7'b1111111, 1'b1);
        wait_n(28); check_output("en_idx3", 4'b0111, 7'b0000000, 1'b1);

        // Randomized loads and suppression toggling, checked by the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       digits = 16'($urandom);
                1:       digits = 16'($urandom) & 16'h00FF;
                2:       digits = 16'($urandom) & 16'h000F;
                default: digits = 16'($urandom) & 16'h0F0F;
            endcase
            digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
        end
        load  = 1'b0;
        lz_en = 1'b0;

        // Asynchronous reset mid-drive discards pending data.
        apply_stimulus(16'h4567, 4'hF, 4'h0);
        wait_n(0);
        wait_n(4);  check_output("pre_rst_idx0", 4'b1110, 7'b1111000, 1'b1);
        apply_stimulus(16'h9999, 4'hF, 4'h0);
        #2 rst = 1'b1;
        #1 check_output("async_rst", 4'b1111, 7'b1111111, 1'b1);
        check_fd("async_rst_fd", 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_n(4);  check_output("post_rst_f0", 4'b1111, 7'b1111111, 1'b1);
        wait_n(0);
        wait_n(4);  check_output("post_rst_f1", 4'b1111, 7'b1111111, 1'b1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_scan_driver.md
DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4; number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 10000; clock cycles per digit slot, legal minimum 4.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16; all-anodes-off cycles at the start of each slot, legal range 1..REFRESH_DIV-1.
REQ-004 SHALL have port clk, input, 1 bit; sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-006 SHALL have port digits, input, 4*NUM_DIGITS bits; nibble i is the hex value of digit i, where digit 0 is least significant.
REQ-007 SHALL have port dp_in, input, NUM_DIGITS bits; decimal point request per digit, 1 = lit.
REQ-008 SHALL have port digit_en, input, NUM_DIGITS bits; 1 = digit is displayed.
REQ-009 SHALL have port load, input, 1 bit; single-cycle strobe that captures digits, dp_in and digit_en.
REQ-010 SHALL have port lz_en, input, 1 bit; leading-zero suppression enable, sampled live.
REQ-011 SHALL have port an, output, NUM_DIGITS bits; anode drive, active-low.
REQ-012 SHALL have port seg, output, 7 bits; segments {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port dp, output, 1 bit; decimal point, active-low.
REQ-014 SHALL have port frame_done, output, 1 bit; one-cycle pulse at the end of each full scan.

Function
REQ-015 SHALL keep slot counter cnt (0..REFRESH_DIV-1), incrementing every cycle and wrapping to 0 after REFRESH_DIV-1.
REQ-016 SHALL keep digit index idx (0..NUM_DIGITS-1), advancing when cnt wraps; idx NUM_DIGITS-1 wraps to 0.
REQ-017 SHALL implement two states: BLANK while cnt < BLANK_CYCLES, DRIVE otherwise.
REQ-018 SHALL hold all outputs an, seg and dp all-ones in BLANK, for ghosting suppression.
REQ-019 SHALL, in DRIVE, drive an with only bit idx low, seg with decode(active nibble idx) and dp with ~active_dp[idx], provided digit idx is visible; otherwise an, seg and dp SHALL be all-ones.
REQ-020 SHALL treat digit idx as visible when active_en[idx]=1 and it is not suppressed.
REQ-021 SHALL treat digit i as suppressed when lz_en=1, i>0, and every digit j>=i has an active nibble of 0 with active_dp[j]=0; digit 0 SHALL never be suppressed.
REQ-022 SHALL decode active-low as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-023 SHALL further decode: 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 SHALL register all outputs; an, seg and dp reflect the (cnt, idx) of the previous cycle, giving a latency of one cycle.
REQ-025 SHALL, on load=1, capture digits, dp_in and digit_en into pending registers.
REQ-026 SHALL copy pending into the active registers when cnt wraps with idx=NUM_DIGITS-1 (the frame boundary); a frame never mixes old and new data.
REQ-027 SHALL, when load coincides with the frame boundary, write the inputs directly into both active and pending.
REQ-028 SHALL pulse frame_done high for one cycle on the cycle following the frame boundary.
REQ-029 SHALL let consecutive loads within one frame overwrite each other; only the last load before the boundary is displayed.

Reset
REQ-030 SHALL, while rst=1, force cnt=0, idx=0, pending=0, active=0, an=all-ones, seg=7'b1111111, dp=1 and frame_done=0.
REQ-031 SHALL, after rst deasserts, start in BLANK with idx=0; the first DRIVE output appears BLANK_CYCLES+1 cycles after the first clock edge.
REQ-032 SHALL treat reset mid-slot or mid-frame as discarding the pending load; no partial frame is completed.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-033 SHALL be verified as follows: after reset, load digits=16'h12AF, digit_en=4'hF, dp_in=0; after the next boundary, slot idx0 shows an=1110, seg=0001110 for 6 cycles after 2 blank cycles; idx3 shows an=0111, seg=1111001.
REQ-034 SHALL be verified as follows: with lz_en=1 and digits=16'h0050, idx3 and idx2 are off (an=1111) and idx1/idx0 show 5/0; with lz_en=1 and digits=16'h0000, only idx0 shows 0.
REQ-035 SHALL be verified as follows: load 16'h1111 mid-frame, then 16'h2222 in the same frame; the next frame shows only 2s and 1 is never displayed.
REQ-036 SHALL be verified as follows: load coinciding with the boundary cycle -> the new value is shown in the immediately following frame; frame_done is exactly 1 cycle wide every 32 cycles.
REQ-037 SHALL be verified as follows: digit_en=4'b1010, dp_in=4'b0010 -> idx1 dp=0, idx0 and idx2 an=1111, idx3 dp=1.
REQ-038 SHALL be verified as follows: assert rst asynchronously mid-DRIVE -> an, seg and dp go all-ones with no clock edge; after release the display is blank until a new load reaches a boundary.
